// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use stalls, MULT/DIV EX occupancy, branch flushes.
// Optional stall-cycle counter output enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_stall_unit #(
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 32,
   parameter int CNT_W    = 6
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       IDEX_MemRead,
   input  logic [4:0] IDEX_Rt,
   input  logic [4:0] IFID_Rs,
   input  logic [4:0] IFID_Rt,
   input  logic       MD_Start,
   input  logic       MD_Op,
   input  logic       Branch_Taken,
   output logic       PC_EN,
   output logic       IFID_EN,
   output logic       IDEX_EN,
   output logic       IDEX_Flush,
   output logic       IFID_Flush,
   output logic       EXMEM_Flush,
   output logic       MD_Busy,
   output logic       MD_Done
`ifdef HAZARD_STALL_COUNT_EN
  ,output logic [31:0] Stall_Count
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             lu;

   // $zero is never a real dependency, so a load into r0 never stalls.
   assign lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
               ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      PC_EN       = 1'b1;
      IFID_EN     = 1'b1;
      IDEX_EN     = 1'b1;
      IDEX_Flush  = 1'b0;
      IFID_Flush  = 1'b0;
      EXMEM_Flush = 1'b0;
      MD_Busy     = 1'b0;
      MD_Done     = 1'b0;
      case (state)
         RUN: begin
            PC_EN       = 1'b0;
            IFID_EN     = 1'b0;
            IDEX_EN     = 1'b0;
            EXMEM_Flush = 1'b1;
            MD_Busy     = 1'b1;
            cnt_nxt     = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nxt = DONE;
         end
         IDLE, DONE: begin
            MD_Done   = (state == DONE);
            state_nxt = IDLE;
            // Load-use wins over a taken branch; the branch re-resolves next cycle.
            if (lu) begin
               PC_EN      = 1'b0;
               IFID_EN    = 1'b0;
               IDEX_Flush = 1'b1;
            end else if (Branch_Taken) begin
               IFID_Flush = 1'b1;
            end
            if (MD_Start) begin
               cnt_nxt   = MD_Op ? DIV_CNT : MULT_CNT;
               state_nxt = (cnt_nxt != '0) ? RUN : DONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

`ifdef HAZARD_STALL_COUNT_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         Stall_Count <= '0;
      else if (!PC_EN && (Stall_Count != '1))
         Stall_Count <= Stall_Count + 32'd1;
   end
`endif

endmodule
